uart_bus_master: RTL and testbench
==================================

# uart_bus_master

UART-driven bus initiator for debug and bring-up: pulls command bytes from the UART RX circular buffer, executes 32-bit reads/writes as an initiator on the PicoRV32-native valid/ready bus, and returns responses through the UART TX core. It sits in the other seat from the CPU: where the memory controller and MMIO peripherals respond to the bus, this block drives it. An external mux or arbiter grants it the bus.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024: bus wait limit in clocks; used only when the timeout feature is compiled in.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high reset
- rx_empty  in  1  RX buffer empty
- rx_data  in  8  RX buffer head byte; valid whenever rx_empty=0 (show-ahead)
- rx_rd_en  out  1  one-cycle pop of the head byte
- tx_data  out  8  byte to transmit
- tx_valid  out  1  one-cycle transmit strobe
- tx_busy  in  1  UART TX busy
- mem_valid  out  1  bus request
- mem_ready  in  1  bus completion
- mem_addr  out  32  word address; bits [1:0] always 0
- mem_wdata  out  32  write data
- mem_wstrb  out  4  4'hF on write, 4'h0 on read
- mem_rdata  in  32  read data, valid while mem_ready=1
- busy  out  1  high whenever state is not IDLE

## Operation
- Command format, multi-byte fields little-endian:
  - Write: 0x57, A0..A3, D0..D3. Response 0x4B.
  - Read: 0x52, A0..A3. Response D0..D3.
  - Any other first byte: response 0x3F, then IDLE.
- States: IDLE -> ADDR (4 bytes) -> [DATA (4 bytes), write only] -> BUS -> RESP -> IDLE.
- Byte intake:
  - rx_rd_en is asserted only when rx_empty=0, at most one pop per cycle.
  - The byte is consumed in the same cycle as the pop.
  - An index counter (0..3) shifts bytes into the addr/data registers, LSB first.
- BUS:
  - mem_valid, mem_addr, mem_wdata and mem_wstrb are held stable until the cycle mem_ready=1 is sampled.
  - mem_rdata is captured in that same cycle.
  - mem_valid deasserts the following cycle.
- RESP:
  - For each response byte, wait for tx_busy=0, then pulse tx_valid for one cycle with tx_data stable.
  - The cycle after the pulse, tx_busy is ignored (guard cycle), so the core has time to raise it.
  - A byte counter selects the read-data byte, 0..3.
- Address bits [1:0] received from the host are discarded.
- No rx_rd_en while in BUS or RESP; incoming bytes queue in the buffer.
- Reset values: rx_rd_en=0, tx_valid=0, tx_data=0, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, busy=0, state=IDLE, all counters 0.
- Reset mid-transaction: all outputs return to reset values immediately (asynchronous). No partial response is sent. Bytes already popped are lost.

## Timing
- Intake: with the buffer non-empty, a write command is fully consumed in 9 consecutive cycles, a read command in 5.
- mem_valid rises the cycle after the last command byte is popped.
- Zero-wait responder: mem_ready is seen in the first mem_valid cycle, so the bus phase is 1 cycle.
- First tx_valid occurs the cycle after mem_ready, provided tx_busy=0.
- An unknown command produces tx_valid with 0x3F the cycle after its pop, provided tx_busy=0.
- Simultaneous conditions:
  - tx_busy falling in the same cycle the guard ends: the byte is sent that cycle.
  - rx_empty deasserting in IDLE: the pop happens that cycle.
- Stalls are unbounded on rx_empty=1, tx_busy=1, and (without the timeout feature) mem_ready=0.

## Configuration
- BUS_TIMEOUT_EN defined:
  - A counter starts at mem_valid rise.
  - If mem_ready is still 0 after TIMEOUT_CYCLES clocks, mem_valid drops the next cycle.
  - The response is a single byte 0x54 for both read and write; no data bytes are sent. State then returns to IDLE.
  - A mem_ready arriving in the same cycle the limit is reached wins; the normal response is sent.
- BUS_TIMEOUT_EN undefined: no counter is present, and BUS waits for mem_ready indefinitely.

## Test plan
- Write path: queue 57 10 00 00 80 EF BE AD DE, ready after 2 cycles -> one bus cycle with mem_addr=0x80000010, wdata=0xDEADBEEF, wstrb=F; response 0x4B.
- Read path: queue 52 07 01 00 00, rdata=0x12345678 -> mem_addr=0x00000104, wstrb=0; TX bytes 78 56 34 12 in order, each strobe only while tx_busy=0.
- Bad opcode: queue 0xAA followed by a valid read -> TX 0x3F, then the read executes normally.
- Backpressure: hold tx_busy=1 for 500 cycles during a read response -> no tx_valid during that window; all 4 bytes arrive afterwards with no byte lost or duplicated.
- Timeout (BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16), mem_ready held 0 -> mem_valid high exactly 16 cycles; TX 0x54; busy=0 afterwards.
- Reset during BUS -> mem_valid=0 and busy=0 asynchronously; a following command completes correctly.

Source files
------------

// File: rtl/uart_bus_master_if.sv
// Bus bundle for uart_bus_master: RX buffer pop side, UART TX core side and
// the PicoRV32-native valid/ready initiator port.
interface uart_bus_master_if;
  logic        rx_empty;
  logic [7:0]  rx_data;
  logic        rx_rd_en;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_busy;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    input  rx_empty, rx_data, tx_busy, mem_ready, mem_rdata,
    output rx_rd_en, tx_data, tx_valid, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    output rx_empty, rx_data, tx_busy, mem_ready, mem_rdata,
    input  rx_rd_en, tx_data, tx_valid, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/uart_bus_master.sv
// UART-driven bus initiator: parses W/R command bytes from the RX buffer,
// runs one 32-bit bus access, and returns the response through UART TX.
// Optional feature: define BUS_TIMEOUT_EN to abort bus accesses that see no
// mem_ready within TIMEOUT_CYCLES clocks (response 0x54).
module uart_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset,
  uart_bus_master_if.master  bus,
  output logic               busy
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP} state_t;
  typedef enum logic [1:0] {R_ACK, R_READ, R_BAD, R_TMO} resp_t;

  state_t      state_q, state_d;
  resp_t       resp_q, resp_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  byte_q, byte_d;
  logic        guard_q, guard_d;
  logic        is_wr_q, is_wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_valid_q, mem_valid_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  logic       rx_pop;
  logic       tx_fire;
  logic [7:0] tx_byte;
  logic       resp_last;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      resp_q      <= R_ACK;
      idx_q       <= '0;
      byte_q      <= '0;
      guard_q     <= 1'b0;
      is_wr_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rdata_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
`ifdef BUS_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      resp_q      <= resp_d;
      idx_q       <= idx_d;
      byte_q      <= byte_d;
      guard_q     <= guard_d;
      is_wr_q     <= is_wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rdata_q     <= rdata_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
`ifdef BUS_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  // Response byte selection for the current response kind / byte index
  always_comb begin
    tx_byte   = 8'h00;
    resp_last = 1'b1;
    case (resp_q)
      R_ACK:  tx_byte = 8'h4B;
      R_BAD:  tx_byte = 8'h3F;
      R_TMO:  tx_byte = 8'h54;
      R_READ: begin
        resp_last = (byte_q == 2'd3);
        case (byte_q)
          2'd0:    tx_byte = rdata_q[7:0];
          2'd1:    tx_byte = rdata_q[15:8];
          2'd2:    tx_byte = rdata_q[23:16];
          default: tx_byte = rdata_q[31:24];
        endcase
      end
      default: tx_byte = 8'h00;
    endcase
  end

  // Command parser, bus sequencing and response pacing
  always_comb begin
    state_d     = state_q;
    resp_d      = resp_q;
    idx_d       = idx_q;
    byte_d      = byte_q;
    guard_d     = guard_q;
    is_wr_d     = is_wr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rdata_d     = rdata_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
`ifdef BUS_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif
    rx_pop      = 1'b0;
    tx_fire     = 1'b0;

    case (state_q)
      S_IDLE: begin
        idx_d   = '0;
        byte_d  = '0;
        guard_d = 1'b0;
`ifdef BUS_TIMEOUT_EN
        tmo_d   = '0;
`endif
        if (!bus.rx_empty) begin
          rx_pop = 1'b1;
          case (bus.rx_data)
            8'h57: begin is_wr_d = 1'b1; state_d = S_ADDR; end
            8'h52: begin is_wr_d = 1'b0; state_d = S_ADDR; end
            default: begin resp_d = R_BAD; state_d = S_RESP; end
          endcase
        end
      end

      S_ADDR: begin
        if (!bus.rx_empty) begin
          rx_pop = 1'b1;
          addr_d = {bus.rx_data, addr_q[31:8]};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            if (is_wr_q) begin
              state_d = S_DATA;
            end else begin
              // Launch the read straight from the final address byte so
              // mem_valid rises the next cycle; low address bits dropped.
              state_d     = S_BUS;
              mem_valid_d = 1'b1;
              mem_addr_d  = {bus.rx_data, addr_q[31:10], 2'b00};
              mem_wdata_d = '0;
              mem_wstrb_d = 4'h0;
            end
          end
        end
      end

      S_DATA: begin
        if (!bus.rx_empty) begin
          rx_pop = 1'b1;
          data_d = {bus.rx_data, data_q[31:8]};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d     = S_BUS;
            mem_valid_d = 1'b1;
            mem_addr_d  = {addr_q[31:2], 2'b00};
            mem_wdata_d = {bus.rx_data, data_q[31:8]};
            mem_wstrb_d = 4'hF;
          end
        end
      end

      S_BUS: begin
        if (bus.mem_ready) begin
          mem_valid_d = 1'b0;
          mem_wstrb_d = 4'h0;
          rdata_d     = bus.mem_rdata;
          resp_d      = is_wr_q ? R_ACK : R_READ;
          byte_d      = '0;
          guard_d     = 1'b0;
          state_d     = S_RESP;
`ifdef BUS_TIMEOUT_EN
        end else if (tmo_q == TMO_LAST) begin
          mem_valid_d = 1'b0;
          mem_wstrb_d = 4'h0;
          resp_d      = R_TMO;
          byte_d      = '0;
          guard_d     = 1'b0;
          state_d     = S_RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
`endif
        end
      end

      S_RESP: begin
        if (guard_q) begin
          guard_d = 1'b0;
        end else if (!bus.tx_busy) begin
          tx_fire = 1'b1;
          if (resp_last) begin
            state_d = S_IDLE;
          end else begin
            byte_d  = byte_q + 2'd1;
            guard_d = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.rx_rd_en  = rx_pop && !reset;
  assign bus.tx_valid  = tx_fire;
  assign bus.tx_data   = (state_q == S_RESP) ? tx_byte : 8'h00;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_bus_master.sv
// Scoreboard bench for uart_bus_master: a command-level reference model
// queues expected bus accesses and TX bytes; independent monitors compare
// them whenever the DUT presents a bus completion or a TX strobe.
module tb_uart_bus_master;

  logic clk = 1'b0;
  logic reset;
  logic busy;

  always #10 clk = ~clk;

  uart_bus_master_if bus_if();

  uart_bus_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .busy  (busy)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } bus_exp_t;

  bus_exp_t   exp_bus[$];
  logic [7:0] exp_tx[$];
  logic [7:0] rx_q[$];

  int n_chk  = 0;
  int n_pass = 0;
  int ready_lat   = -1;
  bit ready_block = 1'b0;
  bit tx_hold     = 1'b0;
  int tx_pulses   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic void rx_refresh();
    bus_if.rx_empty = (rx_q.size() == 0);
    bus_if.rx_data  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  endfunction

  // Reference model: a command turns into bytes for the RX buffer plus the
  // bus access and TX bytes the host should observe.
  task automatic send_cmd(input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] rdata,
                          input bit expect_it);
    bus_exp_t e;
    rx_q.push_back(op);
    if (op == 8'h57 || op == 8'h52) begin
      for (int unsigned i = 0; i < 4; i++) rx_q.push_back(addr[8*i +: 8]);
    end
    if (op == 8'h57) begin
      for (int unsigned i = 0; i < 4; i++) rx_q.push_back(data[8*i +: 8]);
    end
    if (expect_it) begin
      e.addr  = addr & 32'hFFFF_FFFC;
      e.rdata = rdata;
      if (op == 8'h57) begin
        e.wdata = data;
        e.wstrb = 4'hF;
        exp_bus.push_back(e);
        exp_tx.push_back(8'h4B);
      end else if (op == 8'h52) begin
        e.wdata = 32'h0;
        e.wstrb = 4'h0;
        exp_bus.push_back(e);
        for (int unsigned i = 0; i < 4; i++) exp_tx.push_back(rdata[8*i +: 8]);
      end else begin
        exp_tx.push_back(8'h3F);
      end
    end
    rx_refresh();
  endtask

  task automatic at_slot();
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_tx.size() != 0 || exp_bus.size() != 0 || rx_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_leftover"}, exp_tx.size() + exp_bus.size() + rx_q.size() + int'(busy), 0);
    exp_tx.delete();
    exp_bus.delete();
    repeat (6) @(posedge clk);
  endtask

  // RX buffer model: pop at the edge following a sampled rx_rd_en
  initial begin
    bit pop;
    forever begin
      @(negedge clk);
      pop = bus_if.rx_rd_en;
      if (pop) chk("rd_en_while_empty", bus_if.rx_empty, 1'b0);
      @(posedge clk);
      #1;
      if (pop && rx_q.size() != 0) void'(rx_q.pop_front());
      rx_refresh();
    end
  end

  // UART TX core model + TX monitor
  initial begin
    bit sent;
    int bcnt = 0;
    bus_if.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      sent = bus_if.tx_valid;
      if (sent) begin
        tx_pulses++;
        chk("tx_while_busy", bus_if.tx_busy, 1'b0);
        if (exp_tx.size() == 0) chk("unexpected_tx", {24'h0, bus_if.tx_data}, 32'h100);
        else chk("tx_byte", bus_if.tx_data, exp_tx.pop_front());
      end
      @(posedge clk);
      #1;
      if (sent) bcnt = $urandom_range(0, 3);
      if (tx_hold) bus_if.tx_busy = 1'b1;
      else if (bcnt > 0) begin bus_if.tx_busy = 1'b1; bcnt--; end
      else bus_if.tx_busy = 1'b0;
    end
  end

  // Bus responder: completes after ready_lat (or random) wait cycles
  initial begin
    int wl = 0;
    bit in_t = 1'b0;
    bus_if.mem_ready = 1'b0;
    bus_if.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus_if.mem_valid) begin
        if (!in_t) begin
          in_t = 1'b1;
          wl = (ready_lat >= 0) ? ready_lat : int'($urandom_range(0, 3));
        end
        if (ready_block || wl > 0) begin
          bus_if.mem_ready = 1'b0;
          bus_if.mem_rdata = $urandom();
          if (!ready_block) wl--;
        end else begin
          bus_if.mem_ready = 1'b1;
          bus_if.mem_rdata = (exp_bus.size() != 0) ? exp_bus[0].rdata : $urandom();
        end
      end else begin
        in_t = 1'b0;
        bus_if.mem_ready = 1'b0;
        bus_if.mem_rdata = $urandom();
      end
    end
  end

  // Bus monitor: stability while waiting, scoreboard compare on completion
  initial begin
    bus_exp_t e, snap;
    bit in_t = 1'b0;
    bit prev_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_rdy) chk("valid_after_ready", bus_if.mem_valid, 1'b0);
      prev_rdy = 1'b0;
      if (bus_if.mem_valid) begin
        if (!in_t) begin
          in_t = 1'b1;
          snap.addr  = bus_if.mem_addr;
          snap.wdata = bus_if.mem_wdata;
          snap.wstrb = bus_if.mem_wstrb;
        end else begin
          chk("addr_stable", bus_if.mem_addr, snap.addr);
          chk("wdata_stable", bus_if.mem_wdata, snap.wdata);
          chk("wstrb_stable", bus_if.mem_wstrb, snap.wstrb);
        end
        if (bus_if.mem_ready) begin
          prev_rdy = 1'b1;
          in_t = 1'b0;
          if (exp_bus.size() == 0) begin
            chk("unexpected_bus", bus_if.mem_addr, 32'hFFFF_FFFF);
          end else begin
            e = exp_bus.pop_front();
            chk("mem_addr", bus_if.mem_addr, e.addr);
            chk("mem_wstrb", bus_if.mem_wstrb, e.wstrb);
            if (e.wstrb == 4'hF) chk("mem_wdata", bus_if.mem_wdata, e.wdata);
          end
        end
      end else begin
        in_t = 1'b0;
      end
    end
  end

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int p0;
    logic [7:0] op;
    reset = 1'b1;
    rx_refresh();

    repeat (3) @(posedge clk);
    #5;
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_valid", bus_if.mem_valid, 1'b0);
    chk("rst_mem_addr", bus_if.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus_if.mem_wdata, 32'h0);
    chk("rst_mem_wstrb", bus_if.mem_wstrb, 4'h0);
    chk("rst_tx_valid", bus_if.tx_valid, 1'b0);
    chk("rst_tx_data", bus_if.tx_data, 8'h00);
    chk("rst_rx_rd_en", bus_if.rx_rd_en, 1'b0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Write path: 9-cycle intake, ready after 2 wait cycles
    ready_lat = 2;
    at_slot();
    send_cmd(8'h57, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 1'b1);
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (bus_if.mem_valid) break;
      n++;
    end
    chk("write_intake_cycles", n, 9);
    drain("write", 300);

    // Read path: zero-wait responder, first TX the cycle after mem_ready
    ready_lat = 0;
    at_slot();
    send_cmd(8'h52, 32'h0000_0107, 32'h0, 32'h1234_5678, 1'b1);
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (bus_if.mem_valid) break;
      n++;
    end
    chk("read_intake_cycles", n, 5);
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (bus_if.tx_valid) break;
      n++;
    end
    chk("read_first_tx_delay", n, 0);
    drain("read", 300);

    // Unknown opcode followed by a valid read
    ready_lat = -1;
    at_slot();
    send_cmd(8'hAA, 32'h0, 32'h0, 32'h0, 1'b1);
    send_cmd(8'h52, $urandom(), 32'h0, $urandom(), 1'b1);
    drain("bad_op", 300);

    // TX backpressure for 500 cycles during a read response
    tx_hold = 1'b1;
    repeat (2) @(posedge clk);
    at_slot();
    send_cmd(8'h52, $urandom(), 32'h0, $urandom(), 1'b1);
    p0 = tx_pulses;
    repeat (500) @(posedge clk);
    chk("bp_no_tx", tx_pulses - p0, 0);
    chk("bp_busy_held", busy, 1'b1);
    tx_hold = 1'b0;
    drain("backpressure", 300);

`ifdef BUS_TIMEOUT_EN
    // No mem_ready: valid held exactly TIMEOUT_CYCLES, then 0x54
    ready_block = 1'b1;
    at_slot();
    send_cmd(8'h52, 32'h0000_2000, 32'h0, 32'h0, 1'b0);
    exp_tx.push_back(8'h54);
    n = 0;
    while (!bus_if.mem_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (bus_if.mem_valid && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("timeout_valid_cycles", n, 16);
    ready_block = 1'b0;
    drain("timeout", 300);
    chk("timeout_busy_after", busy, 1'b0);
`endif

    // Asynchronous reset while the bus access is pending
    ready_block = 1'b1;
    at_slot();
    send_cmd(8'h52, 32'h0000_0040, 32'h0, 32'h0, 1'b0);
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (bus_if.mem_valid) break;
      n++;
    end
    chk("pre_reset_in_bus", bus_if.mem_valid, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_mem_valid", bus_if.mem_valid, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_tx_valid", bus_if.tx_valid, 1'b0);
    @(posedge clk);
    #5;
    reset = 1'b0;
    ready_block = 1'b0;
    rx_q.delete();
    rx_refresh();
    repeat (3) @(posedge clk);
    at_slot();
    send_cmd(8'h57, $urandom(), $urandom(), 32'h0, 1'b1);
    drain("after_reset", 300);

    // Randomized command stream, commands queue up in the RX buffer
    ready_lat = -1;
    for (int i = 0; i < 40; i++) begin
      at_slot();
      n = $urandom_range(0, 9);
      if (n < 5) op = 8'h57;
      else if (n < 9) op = 8'h52;
      else begin
        do op = 8'($urandom()); while (op == 8'h57 || op == 8'h52);
      end
      send_cmd(op, $urandom(), $urandom(), $urandom(), 1'b1);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(0, 20)) @(posedge clk);
    end
    drain("random", 8000);
    chk("final_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
